// File: rtl/key_debounce_onehot.sv
// key_debounce_onehot: 4-key debouncer feeding a one-hot 4-to-2 encoder.
// Single-key presses drive w3..w0 plus a valid pulse; chords raise multi.
module key_debounce_onehot #(
  parameter int DEB_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] key,
  output logic       w3,
  output logic       w2,
  output logic       w1,
  output logic       w0,
  output logic       valid,
  output logic       multi
);

  typedef enum logic [2:0] {
    IDLE,
    DEBOUNCE,
    HELD,
    MULTI,
    RELEASE
  } state_t;

  localparam logic [7:0] DEB = 8'(DEB_CYCLES);

  state_t     state;
  state_t     state_n;
  logic [3:0] sync1;
  logic [3:0] s;
  logic [3:0] snap;
  logic [3:0] snap_n;
  logic [3:0] w;
  logic [3:0] w_n;
  logic [7:0] cnt;
  logic [7:0] cnt_n;
  logic       valid_n;
  logic       multi_n;
  logic       one_hot;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 4'd0;
      s     <= 4'd0;
    end else begin
      sync1 <= key;
      s     <= sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 8'd0;
      snap  <= 4'd0;
      w     <= 4'd0;
      valid <= 1'b0;
      multi <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      snap  <= snap_n;
      w     <= w_n;
      valid <= valid_n;
      multi <= multi_n;
    end
  end

  // snap is known nonzero whenever this is consulted
  assign one_hot = (snap & (snap - 4'd1)) == 4'd0;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    snap_n  = snap;
    w_n     = w;
    valid_n = 1'b0;
    multi_n = multi;
    unique case (state)
      IDLE: begin
        if (s != 4'd0) begin
          state_n = DEBOUNCE;
          snap_n  = s;
          cnt_n   = 8'd1;
        end
      end
      DEBOUNCE: begin
        if (s == 4'd0) begin
          state_n = IDLE;
          cnt_n   = 8'd0;
        end else if (s != snap) begin
          snap_n = s;
          cnt_n  = 8'd1;
        end else if (cnt < DEB) begin
          cnt_n = cnt + 8'd1;
        end else if (one_hot) begin
          state_n = HELD;
          w_n     = snap;
          valid_n = 1'b1;
        end else begin
          state_n = MULTI;
          multi_n = 1'b1;
        end
      end
      HELD, MULTI: begin
        if (s != snap) begin
          state_n = RELEASE;
          cnt_n   = 8'd0;
          w_n     = 4'd0;
          multi_n = 1'b0;
        end
      end
      RELEASE: begin
        if (s != 4'd0) begin
          cnt_n = 8'd0;
        end else if (cnt >= DEB - 8'd1) begin
          state_n = IDLE;
          cnt_n   = 8'd0;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = 8'd0;
      end
    endcase
  end

  assign w3 = w[3];
  assign w2 = w[2];
  assign w1 = w[1];
  assign w0 = w[0];

endmodule

// File: tb/tb_key_debounce_onehot.sv
// Bench for key_debounce_onehot (DEB_CYCLES=4): run-length model compared
// every cycle, plus directed scenarios with literal expectations.
module tb_key_debounce_onehot;

  localparam int D = 4;

  logic       clk;
  logic       rst_n;
  logic [3:0] key;
  logic       w3, w2, w1, w0;
  logic       valid;
  logic       multi;

  int vectors     = 0;
  int miscompares = 0;
  int vcnt        = 0;
  int vcnt0       = 0;
  logic [3:0] wseen = 4'd0;

  key_debounce_onehot #(.DEB_CYCLES(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .key   (key),
    .w3    (w3),
    .w2    (w2),
    .w1    (w1),
    .w0    (w0),
    .valid (valid),
    .multi (multi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model: phase 0 armed, 1 single held, 2 chord held, 3 waiting for quiet
  int         phase = 0;
  int         run   = 0;
  int         quiet = 0;
  logic [3:0] k1    = 4'd0;
  logic [3:0] sm    = 4'd0;
  logic [3:0] cand  = 4'd0;
  logic [3:0] ew    = 4'd0;
  logic       ev    = 1'b0;
  logic       em    = 1'b0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      phase = 0; run = 0; quiet = 0;
      k1 = 4'd0; sm = 4'd0; cand = 4'd0;
      ew = 4'd0; ev = 1'b0; em = 1'b0;
    end else begin
      ev = 1'b0;
      case (phase)
        0: begin
          // qualify once one nonzero pattern has been seen D+1 edges running
          if (sm == 4'd0) run = 0;
          else begin
            if (run > 0 && sm == cand) run++;
            else begin cand = sm; run = 1; end
            if (run == D + 1) begin
              run = 0;
              if ($countones(cand) == 1) begin
                phase = 1; ew = cand; ev = 1'b1;
              end else begin
                phase = 2; em = 1'b1;
              end
            end
          end
        end
        1, 2: begin
          if (sm != cand) begin
            phase = 3; quiet = 0; ew = 4'd0; em = 1'b0;
          end
        end
        default: begin
          quiet = (sm == 4'd0) ? quiet + 1 : 0;
          if (quiet == D) begin phase = 0; run = 0; end
        end
      endcase
      sm = k1;
      k1 = key;
    end
  end

  task automatic chk(input string name, input logic [3:0] act,
                     input logic [3:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(negedge clk);
    chk("model_w", {w3, w2, w1, w0}, ew);
    chk("model_valid", {3'd0, valid}, {3'd0, ev});
    chk("model_multi", {3'd0, multi}, {3'd0, em});
    if (valid) vcnt++;
    wseen = wseen | {w3, w2, w1, w0};
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    key   = 4'd0;
    tick(2);
    chk("reset_w", {w3, w2, w1, w0}, 4'b0000);
    chk("reset_vm", {2'd0, valid, multi}, 4'b0000);
    rst_n = 1'b1;
    tick(3);

    // single key 0100
    key = 4'b0100;
    tick(6);
    chk("p0100_early_w", {w3, w2, w1, w0}, 4'b0000);
    tick(1);
    chk("p0100_w", {w3, w2, w1, w0}, 4'b0100);
    chk("p0100_valid", {3'd0, valid}, 4'd1);
    chk("p0100_multi", {3'd0, multi}, 4'd0);
    tick(1);
    chk("p0100_valid_one", {3'd0, valid}, 4'd0);
    chk("p0100_hold", {w3, w2, w1, w0}, 4'b0100);
    key = 4'd0;
    tick(12);

    // short glitch
    vcnt0 = vcnt; wseen = 4'd0;
    key = 4'b0001;
    tick(3);
    key = 4'd0;
    tick(12);
    chk("glitch_valid", 4'(vcnt - vcnt0), 4'd0);
    chk("glitch_w", wseen, 4'd0);

    // chord 1010
    vcnt0 = vcnt; wseen = 4'd0;
    key = 4'b1010;
    tick(6);
    chk("chord_early", {3'd0, multi}, 4'd0);
    tick(1);
    chk("chord_multi", {3'd0, multi}, 4'd1);
    chk("chord_w", {w3, w2, w1, w0}, 4'b0000);
    key = 4'd0;
    tick(2);
    chk("chord_still", {3'd0, multi}, 4'd1);
    tick(1);
    chk("chord_clear", {3'd0, multi}, 4'd0);
    tick(10);
    chk("chord_novalid", 4'(vcnt - vcnt0), 4'd0);
    chk("chord_now", wseen, 4'd0);

    // w1 held then a second key joins
    key = 4'b0010;
    tick(8);
    chk("add_w1", {w3, w2, w1, w0}, 4'b0010);
    vcnt0 = vcnt;
    key = 4'b0011;
    tick(2);
    chk("add_w1_still", {w3, w2, w1, w0}, 4'b0010);
    tick(1);
    chk("add_w1_clear", {w3, w2, w1, w0}, 4'b0000);
    tick(10);
    chk("add_nomulti", {3'd0, multi}, 4'd0);
    chk("add_novalid", 4'(vcnt - vcnt0), 4'd0);
    key = 4'd0;
    tick(10);
    key = 4'b0011;
    tick(6);
    chk("add_new_early", {3'd0, multi}, 4'd0);
    tick(1);
    chk("add_new_multi", {3'd0, multi}, 4'd1);
    key = 4'd0;
    tick(12);

    // bouncing 1000
    vcnt0 = vcnt;
    for (int i = 0; i < 10; i++) begin
      key = (i % 2 == 0) ? 4'b1000 : 4'b0000;
      tick(1);
    end
    key = 4'b1000;
    tick(6);
    chk("bounce_early", {w3, w2, w1, w0}, 4'b0000);
    tick(1);
    chk("bounce_w3", {w3, w2, w1, w0}, 4'b1000);
    tick(4);
    chk("bounce_one_valid", 4'(vcnt - vcnt0), 4'd1);
    key = 4'd0;
    tick(12);

    // reset while w0 held
    key = 4'b0001;
    tick(8);
    chk("rst_pre_w0", {w3, w2, w1, w0}, 4'b0001);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_now_w", {w3, w2, w1, w0}, 4'b0000);
    chk("rst_now_vm", {2'd0, valid, multi}, 4'b0000);
    tick(2);
    vcnt0 = vcnt;
    rst_n = 1'b1;
    tick(6);
    chk("rst_req_early", {w3, w2, w1, w0}, 4'b0000);
    tick(1);
    chk("rst_req_w0", {w3, w2, w1, w0}, 4'b0001);
    chk("rst_req_valid", {3'd0, valid}, 4'd1);
    tick(3);
    chk("rst_one_valid", 4'(vcnt - vcnt0), 4'd1);
    key = 4'd0;
    tick(12);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/key_debounce_onehot.md
KEY_DEBOUNCE_ONEHOT -- requirements
Module: key_debounce_onehot

Interface
REQ-001 Parameter DEB_CYCLES, default 16, legal 2..255: number of consecutive stable sampled cycles that qualify a press or a release.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 key  input  4  raw push-button lines; asynchronous to clk; active-high; key[i] is request i.
REQ-005 w3, w2, w1, w0  output  1 each  registered one-hot request lines for the downstream 4-to-2 encoder; w<i> mirrors qualified key[i].
REQ-006 valid  output  1  one-cycle pulse when a single-key press is qualified.
REQ-007 multi  output  1  level; a qualified press has more than one key set.

Function
REQ-008 key SHALL pass through a 2-flop synchronizer; the second-flop value is called s[3:0]; all FSM decisions SHALL use s only.
REQ-009 FSM states SHALL be IDLE, DEBOUNCE, HELD, MULTI, RELEASE; a counter cnt of 8 bits and a 4-bit snapshot snap SHALL be kept.
REQ-010 IDLE: if s != 0 -> DEBOUNCE, snap <= s, cnt <= 1; else stay.
REQ-011 DEBOUNCE, s == 0 -> IDLE.
REQ-012 DEBOUNCE, s != 0 and s != snap -> stay, snap <= s, cnt <= 1 (restart qualification).
REQ-013 DEBOUNCE, s == snap and cnt < DEB_CYCLES -> cnt <= cnt + 1.
REQ-014 DEBOUNCE, s == snap and cnt == DEB_CYCLES: exactly one bit of snap set -> HELD, {w3,w2,w1,w0} <= snap, valid pulse; two or more bits set -> MULTI, multi <= 1, w outputs stay 0.
REQ-015 HELD: outputs held constant; any s != snap (release, glitch, or added key) -> RELEASE, cnt <= 0, all w outputs cleared on that same edge.
REQ-016 MULTI: multi held 1; any s != snap -> RELEASE, cnt <= 0, multi cleared on that same edge.
REQ-017 RELEASE: s != 0 -> cnt <= 0; s == 0 -> cnt <= cnt + 1; after DEB_CYCLES consecutive s == 0 cycles -> IDLE. No new press SHALL be accepted before IDLE is reached.
REQ-018 valid SHALL be high for exactly one cycle per HELD entry and never in any other state.
REQ-019 {w3,w2,w1,w0} SHALL be either 0000 or exactly one bit set in every cycle; w outputs and multi SHALL never be high simultaneously.
REQ-020 Press latency: key stable from the first sampling edge (edge 0) -> w and valid high after edge DEB_CYCLES+2.
REQ-021 cnt SHALL saturate at DEB_CYCLES; no wrap-around in any state.
REQ-022 Glitches shorter than DEB_CYCLES sampled cycles SHALL never produce valid, w, or multi.

Reset
REQ-023 rst_n low SHALL immediately force state IDLE, cnt 0, snap 0, synchronizer flops 0, w3..w0 0, valid 0, multi 0, regardless of clk.
REQ-024 Reset asserted mid-HELD or mid-DEBOUNCE SHALL drop outputs without a valid pulse; after release, a still-held key SHALL be re-qualified from IDLE with full REQ-020 latency.
REQ-025 Reset deassertion needs no synchronization inside this block; the release edge is provided synchronous to clk externally.

Verification (DEB_CYCLES = 4)
REQ-026 key=0100 held from edge 0 -> w2=1 and a one-cycle valid after edge 6; w3,w1,w0=0; multi=0.
REQ-027 key=0001 for 3 cycles then 0 -> no valid and w0 never 1; FSM returns to IDLE.
REQ-028 key=1010 held -> multi=1 after edge 6, w all 0, no valid; key to 0 -> multi clears; IDLE after 4 zero cycles.
REQ-029 w1 held; key changes to 0011 -> w1 clears on the next edge after s changes, no valid, no multi until release is qualified and a new press completes.
REQ-030 key=1000 bouncing 1/0 every cycle for 10 cycles then stable -> exactly one valid and w3=1 after DEB_CYCLES+2 edges measured from the last bounce.
REQ-031 rst_n pulsed low while w0=1 and key still 0001 -> w0=0 immediately; after release, w0=1 again after edge 6 with one new valid.
